// File: rtl/dsp_rr_scheduler.sv
// dsp_rr_scheduler: round-robin share of one pipelined DSP multiplier between two requesters, with tagged product return
module dsp_rr_scheduler #(
  parameter int DATA_WIDTH  = 4,
  parameter int MUL_WIDTH   = 25,
  parameter int BRAM_WIDTH  = 18,
  parameter int DSP_LATENCY = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req0_valid,
  input  logic [DATA_WIDTH-1:0]           req0_a,
  input  logic [DATA_WIDTH-1:0]           req0_b,
  output logic                            req0_ready,
  input  logic                            req1_valid,
  input  logic [DATA_WIDTH-1:0]           req1_a,
  input  logic [DATA_WIDTH-1:0]           req1_b,
  output logic                            req1_ready,
  output logic                            rsp0_valid,
  output logic [2*DATA_WIDTH-1:0]         rsp0_data,
  output logic                            rsp1_valid,
  output logic [2*DATA_WIDTH-1:0]         rsp1_data,
  output logic [MUL_WIDTH-1:0]            dsp_a,
  output logic [BRAM_WIDTH-1:0]           dsp_b,
  input  logic [MUL_WIDTH+BRAM_WIDTH-1:0] dsp_p,
  output logic                            busy
);
  if (!(DATA_WIDTH <= BRAM_WIDTH && BRAM_WIDTH <= MUL_WIDTH && DSP_LATENCY >= 1)) begin : g_bad_params
    $fatal(1, "dsp_rr_scheduler: illegal parameters");
  end
  logic                   last_grant;
  logic                   g0;
  logic                   g1;
  logic                   xfer;
  logic [DSP_LATENCY:0]   tv;
  logic [DSP_LATENCY:0]   tid;
  logic                   tail0;
  logic                   tail1;
  logic                   unused_hi;
  always_comb begin
    g0    = !rst && req0_valid && (!req1_valid || last_grant);
    g1    = !rst && req1_valid && (!req0_valid || !last_grant);
    xfer  = g0 || g1;
    tail0 = tv[DSP_LATENCY] && !tid[DSP_LATENCY];
    tail1 = tv[DSP_LATENCY] && tid[DSP_LATENCY];
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign busy       = |tv || rsp0_valid || rsp1_valid;
  assign unused_hi  = ^dsp_p[MUL_WIDTH+BRAM_WIDTH-1:2*DATA_WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      dsp_a      <= '0;
      dsp_b      <= '0;
      tv         <= '0;
      tid        <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      if (xfer) begin
        last_grant <= g1;
        dsp_a      <= MUL_WIDTH'(g1 ? req1_a : req0_a);
        dsp_b      <= BRAM_WIDTH'(g1 ? req1_b : req0_b);
      end
      tv         <= {tv[DSP_LATENCY-1:0], xfer};
      tid        <= {tid[DSP_LATENCY-1:0], g1};
      rsp0_valid <= tail0;
      rsp1_valid <= tail1;
      if (tail0) rsp0_data <= dsp_p[2*DATA_WIDTH-1:0];
      if (tail1) rsp1_data <= dsp_p[2*DATA_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_dsp_rr_scheduler.sv
// tb_dsp_rr_scheduler: directed scenarios plus randomized traffic against a queue-based reference model
module tb_dsp_rr_scheduler;
  localparam int W = 4, MW = 25, BW = 18, L = 3;
  logic clk = 0, rst = 1;
  logic r0v = 0, r1v = 0, r0r, r1r, s0v, s1v, busy;
  logic [W-1:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0;
  logic [2*W-1:0] s0d, s1d;
  logic [MW-1:0] dsp_a;
  logic [BW-1:0] dsp_b;
  logic [MW+BW-1:0] dsp_p, p1, p2;
  int checks = 0, errors = 0;
  typedef struct {int due; bit id; int prod;} ent_t;
  ent_t q[$];

  dsp_rr_scheduler #(.DATA_WIDTH(W), .MUL_WIDTH(MW), .BRAM_WIDTH(BW), .DSP_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0r),
    .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1r),
    .rsp0_valid(s0v), .rsp0_data(s0d), .rsp1_valid(s1v), .rsp1_data(s1d),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_p(dsp_p), .busy(busy));

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    p1    <= (MW+BW)'(dsp_a) * (MW+BW)'(dsp_b);
    p2    <= p1;
    dsp_p <= p2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1; r0v = 0; r1v = 0;
    tick; tick;
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; r0v = 1; r1v = 1; r0a = 5; r0b = 6; r1a = 7; r1b = 8;
    #1;
    checks++; if (r0r !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %0b exp 0", r0r); end
    checks++; if (r1r !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %0b exp 0", r1r); end
    tick; tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", busy); end
    checks++; if (dsp_a !== '0 || dsp_b !== '0) begin errors++; $display("FAIL rst_dsp: got %0h/%0h exp 0/0", dsp_a, dsp_b); end
    checks++; if (s0v !== 1'b0 || s1v !== 1'b0) begin errors++; $display("FAIL rst_rspv: got %0b%0b exp 00", s0v, s1v); end
    checks++; if (s0d !== '0 || s1d !== '0) begin errors++; $display("FAIL rst_rspd: got %0h/%0h exp 0/0", s0d, s1d); end
    rst = 0; r0v = 0; r1v = 0;
    tick;
  endtask

  task automatic test_single;
    do_reset;
    r0v = 1; r0a = 7; r0b = 9;
    #1;
    checks++; if (r0r !== 1'b1 || r1r !== 1'b0) begin errors++; $display("FAIL single_grant: got %0b%0b exp 10", r0r, r1r); end
    tick;
    r0v = 0;
    for (int c = 1; c <= 7; c++) begin
      checks++; if (s0v !== (c == 5)) begin errors++; $display("FAIL single_rsp0v c%0d: got %0b exp %0b", c, s0v, c == 5); end
      checks++; if (s1v !== 1'b0) begin errors++; $display("FAIL single_rsp1v c%0d: got %0b exp 0", c, s1v); end
      checks++; if (busy !== (c <= 5)) begin errors++; $display("FAIL single_busy c%0d: got %0b exp %0b", c, busy, c <= 5); end
      if (c == 5) begin checks++; if (s0d !== 8'd63) begin errors++; $display("FAIL single_data: got %0d exp 63", s0d); end end
      if (c == 1) begin checks++; if (dsp_a !== 25'd7 || dsp_b !== 18'd9) begin errors++; $display("FAIL single_dsp: got %0d/%0d exp 7/9", dsp_a, dsp_b); end end
      tick;
    end
  endtask

  task automatic test_contention;
    do_reset;
    r0v = 1; r0a = 2; r0b = 3; r1v = 1; r1a = 4; r1b = 5;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (r0r !== (k % 2 == 0) || r1r !== (k % 2 == 1)) begin errors++; $display("FAIL cont_grant k%0d: got %0b%0b exp %0b%0b", k, r0r, r1r, k % 2 == 0, k % 2 == 1); end
      tick;
    end
    r0v = 0; r1v = 0;
    for (int c = 4; c <= 9; c++) begin
      checks++; if (s0v !== (c == 5 || c == 7)) begin errors++; $display("FAIL cont_rsp0v c%0d: got %0b", c, s0v); end
      checks++; if (s1v !== (c == 6 || c == 8)) begin errors++; $display("FAIL cont_rsp1v c%0d: got %0b", c, s1v); end
      if (c == 5 || c == 7) begin checks++; if (s0d !== 8'd6) begin errors++; $display("FAIL cont_data0 c%0d: got %0d exp 6", c, s0d); end end
      if (c == 6 || c == 8) begin checks++; if (s1d !== 8'd20) begin errors++; $display("FAIL cont_data1 c%0d: got %0d exp 20", c, s1d); end end
      tick;
    end
  endtask

  task automatic test_max;
    do_reset;
    r1v = 1; r1a = 15; r1b = 15;
    #1;
    checks++; if (r1r !== 1'b1) begin errors++; $display("FAIL max_grant: got %0b exp 1", r1r); end
    tick;
    r1v = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin checks++; if (dsp_a !== 25'h000000F || dsp_b !== 18'h0000F) begin errors++; $display("FAIL max_dsp c%0d: got %0h/%0h exp f/f", c, dsp_a, dsp_b); end end
      checks++; if (s1v !== (c == 5) || s0v !== 1'b0) begin errors++; $display("FAIL max_rspv c%0d: got %0b%0b", c, s0v, s1v); end
      if (c == 5) begin checks++; if (s1d !== 8'd225) begin errors++; $display("FAIL max_data: got %0d exp 225", s1d); end end
      tick;
    end
  endtask

  task automatic test_bubble;
    do_reset;
    for (int c = 0; c <= 8; c++) begin
      r0v = (c == 0 || c == 2);
      r0a = (c == 0) ? 4'd3 : 4'd5;
      r0b = r0a;
      #1;
      if (r0v) begin checks++; if (r0r !== 1'b1) begin errors++; $display("FAIL bubble_grant c%0d: got %0b exp 1", c, r0r); end end
      tick;
      checks++; if (s0v !== (c + 1 == 5 || c + 1 == 7)) begin errors++; $display("FAIL bubble_rspv c%0d: got %0b", c + 1, s0v); end
      if (c + 1 == 5) begin checks++; if (s0d !== 8'd9) begin errors++; $display("FAIL bubble_data5: got %0d exp 9", s0d); end end
      if (c + 1 == 7) begin checks++; if (s0d !== 8'd25) begin errors++; $display("FAIL bubble_data7: got %0d exp 25", s0d); end end
    end
    r0v = 0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    r1v = 1; r1a = 1; r1b = 2;
    tick;
    r1v = 0; r0v = 1; r0a = 3; r0b = 3;
    tick;
    rst = 1; r0v = 1; r1v = 1;
    #1;
    checks++; if (r0r !== 1'b0 || r1r !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %0b%0b exp 00", r0r, r1r); end
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b exp 0", busy); end
    checks++; if (dsp_a !== '0 || dsp_b !== '0) begin errors++; $display("FAIL mid_dsp: got %0h/%0h exp 0/0", dsp_a, dsp_b); end
    rst = 0; r0a = 6; r0b = 7;
    #1;
    checks++; if (r0r !== 1'b1 || r1r !== 1'b0) begin errors++; $display("FAIL mid_regrant: got %0b%0b exp 10", r0r, r1r); end
    tick;
    r0v = 0; r1v = 0;
    for (int c = 4; c <= 9; c++) begin
      checks++; if (s0v !== (c == 8) || s1v !== 1'b0) begin errors++; $display("FAIL mid_rspv c%0d: got %0b%0b exp %0b0", c, s0v, s1v, c == 8); end
      if (c == 8) begin checks++; if (s0d !== 8'd42) begin errors++; $display("FAIL mid_data: got %0d exp 42", s0d); end end
      tick;
    end
  endtask

  task automatic test_priority;
    do_reset;
    r1v = 1; r1a = 2; r1b = 2;
    #1;
    checks++; if (r1r !== 1'b1 || r0r !== 1'b0) begin errors++; $display("FAIL prio_first: got %0b%0b exp 01", r0r, r1r); end
    tick;
    r0v = 1; r0a = 1; r0b = 1;
    #1;
    checks++; if (r0r !== 1'b1 || r1r !== 1'b0) begin errors++; $display("FAIL prio_second: got %0b%0b exp 10", r0r, r1r); end
    tick;
    #1;
    checks++; if (r1r !== 1'b1 || r0r !== 1'b0) begin errors++; $display("FAIL prio_third: got %0b%0b exp 01", r0r, r1r); end
    tick;
    r0v = 0; r1v = 0;
    repeat (6) tick;
  endtask

  task automatic test_random;
    bit mlg, e0, e1, popped;
    logic [7:0] exp_d0, exp_d1, exp_a, exp_b;
    do_reset;
    mlg = 1; exp_d0 = 0; exp_d1 = 0; exp_a = 0; exp_b = 0;
    q.delete();
    for (int e = 0; e < 400; e++) begin
      r0v = (e < 390) && ($urandom_range(0, 3) != 0);
      r1v = (e < 390) && ($urandom_range(0, 2) != 0);
      r0a = 4'($urandom); r0b = 4'($urandom); r1a = 4'($urandom); r1b = 4'($urandom);
      e0 = r0v && (!r1v || mlg);
      e1 = r1v && !e0;
      #1;
      checks++; if (r0r !== e0 || r1r !== e1) begin errors++; $display("FAIL rand_grant e%0d: got %0b%0b exp %0b%0b", e, r0r, r1r, e0, e1); end
      @(posedge clk);
      if (e0 || e1) begin
        mlg = e1;
        exp_a = e1 ? 8'(r1a) : 8'(r0a);
        exp_b = e1 ? 8'(r1b) : 8'(r0b);
        q.push_back('{due: e + L + 1, id: e1, prod: int'(exp_a) * int'(exp_b)});
      end
      #1;
      popped = 0; e0 = 0; e1 = 0;
      if (q.size() > 0 && q[0].due == e) begin
        popped = 1;
        if (q[0].id) begin e1 = 1; exp_d1 = 8'(q[0].prod); end
        else begin e0 = 1; exp_d0 = 8'(q[0].prod); end
        void'(q.pop_front());
      end
      checks++; if (s0v !== e0 || s1v !== e1) begin errors++; $display("FAIL rand_rspv e%0d: got %0b%0b exp %0b%0b", e, s0v, s1v, e0, e1); end
      checks++; if (s0d !== exp_d0 || s1d !== exp_d1) begin errors++; $display("FAIL rand_rspd e%0d: got %0d/%0d exp %0d/%0d", e, s0d, s1d, exp_d0, exp_d1); end
      checks++; if (busy !== (popped || q.size() > 0)) begin errors++; $display("FAIL rand_busy e%0d: got %0b exp %0b", e, busy, popped || q.size() > 0); end
      checks++; if (dsp_a !== MW'(exp_a) || dsp_b !== BW'(exp_b)) begin errors++; $display("FAIL rand_dsp e%0d: got %0d/%0d exp %0d/%0d", e, dsp_a, dsp_b, exp_a, exp_b); end
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending exp 0", q.size()); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_max;
    test_bubble;
    test_reset_mid;
    test_priority;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
